// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream route decoder.
package axis_pkg;

    localparam int MaxPorts = 32;

    typedef enum logic [1:0] {
        StHead = 2'd0,
        StPass = 2'd1,
        StDrop = 2'd2
    } route_state_e;

    function automatic int unsigned popcount(input logic [MaxPorts-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxPorts; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when v is all zero (caller masks that case).
    function automatic int unsigned lowest_set_idx(input logic [MaxPorts-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MaxPorts - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry skid register slice: one-cycle latency, full throughput, registered in_ready.
module axis_skid_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic             in_fire;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        in_fire      = in_valid_i && ready_q;

        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_fire) begin
            // Output stalled: park the beat accepted on the strength of last cycle's ready.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_route_decode.sv
// Header-driven route decoder: derives per-port enables from the first beat of each
// packet, drops unrouted packets and forwards the rest through a skid slice.
module axis_route_decode
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned M_COUNT    = 4,
    parameter int unsigned ROUTE_LSB  = 56,
    parameter int unsigned FORK_BIT   = 60 + M_COUNT - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [M_COUNT-1:0]    port_en,
    input  logic                  cnt_clr,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [M_COUNT-1:0]    m_oen,
    output logic                  m_fork_enable,
    output logic [M_COUNT-1:0]    m_single_mask,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned PayW = DATA_WIDTH + 2 + 2 * M_COUNT;

    route_state_e        state_q;
    logic [M_COUNT-1:0]  route_q, single_q;
    logic                fork_q;
    logic [M_COUNT-1:0]  hdr_route, hdr_single, cur_route, cur_single;
    logic                hdr_fork, cur_fork;
    logic [MaxPorts-1:0] route_ext;
    logic                is_head, fwd, accept, s_ready;
    logic [PayW-1:0]     in_pay, out_pay;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        hdr_route = s_axis_tdata[ROUTE_LSB +: M_COUNT] & port_en;
        route_ext = '0;
        route_ext[M_COUNT-1:0] = hdr_route;
        hdr_fork   = s_axis_tdata[FORK_BIT] && (popcount(route_ext) >= 2);
        hdr_single = (M_COUNT'(1) << lowest_set_idx(route_ext)) & {M_COUNT{|hdr_route}};
    end

    // Header beat uses the live decode; later beats reuse what the header latched.
    assign is_head    = (state_q == StHead);
    assign cur_route  = is_head ? hdr_route  : route_q;
    assign cur_fork   = is_head ? hdr_fork   : fork_q;
    assign cur_single = is_head ? hdr_single : single_q;
    assign fwd        = (state_q == StPass) || (is_head && (hdr_route != '0));
    assign accept     = s_axis_tvalid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StHead;
            route_q  <= '0;
            fork_q   <= 1'b0;
            single_q <= '0;
        end else if (accept) begin
            unique case (state_q)
                StHead: begin
                    route_q  <= hdr_route;
                    fork_q   <= hdr_fork;
                    single_q <= hdr_single;
                    if (!s_axis_tlast) begin
                        state_q <= (hdr_route != '0) ? StPass : StDrop;
                    end
                end
                StPass, StDrop: begin
                    if (s_axis_tlast) begin
                        state_q <= StHead;
                    end
                end
                default: state_q <= StHead;
            endcase
        end
    end

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (cnt_clr) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
        end else if (accept && s_axis_tlast) begin
            if (fwd && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            if (!fwd && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_pay = {s_axis_tdata, s_axis_tlast, cur_route, cur_fork, cur_single};

    axis_skid_slice #(
        .WIDTH (PayW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_pay),
        .in_valid_i  (s_axis_tvalid && fwd),
        .in_ready_o  (s_ready),
        .out_data_o  (out_pay),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

    assign s_axis_tready = s_ready;
    assign {m_axis_tdata, m_axis_tlast, m_oen, m_fork_enable, m_single_mask} = out_pay;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_axis_route_decode.sv
// Directed bench for axis_route_decode with an expected-beat queue and stall-stability checks.
module tb_axis_route_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  port_en;
    logic        cnt_clr;
    logic [63:0] s_data;
    logic        s_last, s_valid, s_ready;
    logic [63:0] m_data;
    logic        m_last, m_valid, m_ready;
    logic [3:0]  m_oen, m_single;
    logic        m_fork;
    logic [15:0] pkt_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    int steps  = 0;
    int seq    = 0;
    int steps0;

    logic [73:0] exp_q[$];
    logic [73:0] prev_out;
    bit          prev_stall = 0;
    bit          no_out = 0;
    bit          rand_ready = 0;

    always #5 clk = ~clk;

    axis_route_decode dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port_en       (port_en),
        .cnt_clr       (cnt_clr),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tlast  (m_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_oen         (m_oen),
        .m_fork_enable (m_fork),
        .m_single_mask (m_single),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score output handshakes, return input acceptance.
    task automatic step(output bit acc);
        logic [73:0] cur;
        logic [73:0] e;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        steps++;
        cur = {m_data, m_last, m_oen, m_fork, m_single};
        if (prev_stall) chk("stall_hold", {m_valid, cur}, {1'b1, prev_out});
        if (no_out) begin
            chk("drop_no_tvalid", m_valid, 1'b0);
            chk("drop_tready", s_ready, 1'b1);
        end
        if (m_valid && m_ready) begin
            chk("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_beat", cur, e);
            end
        end
        acc        = s_valid && s_ready;
        prev_stall = m_valid && !m_ready;
        prev_out   = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        bit acc;
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", acc, 1'b1);
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] route, input bit fk, input int nb, input bit fwd,
                            input logic [3:0] oen, input bit efork, input logic [3:0] single);
        logic [63:0] d;
        for (int i = 0; i < nb; i++) begin
            d = (i == 0) ? {3'b000, fk, route, 56'(seq)} : {8'hA0, 48'(seq), 8'(i)};
            if (fwd) exp_q.push_back({d, 1'(i == nb - 1), oen, efork, single});
            send_beat(d, 1'(i == nb - 1));
        end
        seq++;
    endtask

    task automatic wait_empty();
        bit acc;
        int n;
        n = 0;
        s_valid = 1'b0;
        while ((exp_q.size() != 0 || m_valid) && n < 100) begin
            step(acc);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, m_valid, 1'b0);
        chk({tag, "_tready"}, s_ready, 1'b0);
        chk({tag, "_oen"}, m_oen, 4'h0);
        chk({tag, "_fork"}, m_fork, 1'b0);
        chk({tag, "_single"}, m_single, 4'h0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 16'h0);
        chk({tag, "_drop_cnt"}, drop_cnt, 16'h0);
    endtask

    initial begin
        logic [63:0] d;
        port_en = 4'hF;
        cnt_clr = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", s_ready, 1'b1);

        // Unicast, back-to-back
        steps0 = steps;
        send_pkt(4'b0100, 1'b0, 3, 1'b1, 4'b0100, 1'b0, 4'b0100);
        chk("unicast_throughput", steps - steps0, 3);
        wait_empty();
        chk("pkt_cnt_unicast", pkt_cnt, 16'd1);

        // Multicast with port mask
        port_en = 4'b0111;
        send_pkt(4'b1011, 1'b1, 2, 1'b1, 4'b0011, 1'b1, 4'b0001);
        wait_empty();
        chk("pkt_cnt_multicast", pkt_cnt, 16'd2);

        // Fork requested but only one port survives the mask; single-beat packet
        send_pkt(4'b1001, 1'b1, 1, 1'b1, 4'b0001, 1'b0, 4'b0001);
        wait_empty();
        chk("pkt_cnt_fork_one", pkt_cnt, 16'd3);

        // port_en changes mid-packet: takes effect at the next header only
        port_en = 4'hF;
        d = {3'b000, 1'b0, 4'b1111, 56'h55};
        exp_q.push_back({d, 1'b0, 4'b1111, 1'b0, 4'b0001});
        send_beat(d, 1'b0);
        port_en = 4'b0001;
        for (int i = 1; i < 3; i++) begin
            d = {8'hB0, 48'h0, 8'(i)};
            exp_q.push_back({d, 1'(i == 2), 4'b1111, 1'b0, 4'b0001});
            send_beat(d, 1'(i == 2));
        end
        wait_empty();
        chk("pkt_cnt_pen_mid", pkt_cnt, 16'd4);
        no_out = 1'b1;
        send_pkt(4'b0110, 1'b0, 2, 1'b0, 4'h0, 1'b0, 4'h0);
        no_out = 1'b0;
        chk("drop_cnt_pen_next", drop_cnt, 16'd1);

        // Drop: masked-off route, 5 beats, never presented
        port_en = 4'b0111;
        no_out = 1'b1;
        send_pkt(4'b1000, 1'b0, 5, 1'b0, 4'h0, 1'b0, 4'h0);
        wait_empty();
        send_pkt(4'b0000, 1'b0, 1, 1'b0, 4'h0, 1'b0, 4'h0);
        wait_empty();
        no_out = 1'b0;
        chk("drop_cnt_drop", drop_cnt, 16'd3);
        send_pkt(4'b0010, 1'b0, 2, 1'b1, 4'b0010, 1'b0, 4'b0010);
        wait_empty();
        chk("pkt_cnt_after_drop", pkt_cnt, 16'd5);

        // Random backpressure, 1000 beats
        port_en = 4'hF;
        rand_ready = 1'b1;
        for (int p = 0; p < 250; p++) begin
            send_pkt(4'b0001, 1'b0, 4, 1'b1, 4'b0001, 1'b0, 4'b0001);
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        wait_empty();
        chk("pkt_cnt_backpressure", pkt_cnt, 16'd255);

        // Full throughput with m_axis_tready held high
        steps0 = steps;
        for (int p = 0; p < 4; p++) begin
            send_pkt(4'b1000, 1'b0, 4, 1'b1, 4'b1000, 1'b0, 4'b1000);
        end
        chk("full_throughput", steps - steps0, 16);
        wait_empty();
        chk("pkt_cnt_throughput", pkt_cnt, 16'd259);

        // Reset during beat 2 of 4
        d = {3'b000, 1'b0, 4'b0100, 56'h77};
        exp_q.push_back({d, 1'b0, 4'b0100, 1'b0, 4'b0100});
        send_beat(d, 1'b0);
        d = 64'hA000_0000_0000_0001;
        exp_q.push_back({d, 1'b0, 4'b0100, 1'b0, 4'b0100});
        send_beat(d, 1'b0);
        s_valid = 1'b1;
        s_data  = 64'hA000_0000_0000_0002;
        s_last  = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_reset_outputs("midpkt_reset");
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midpkt", s_ready, 1'b1);
        send_pkt(4'b0010, 1'b0, 2, 1'b1, 4'b0010, 1'b0, 4'b0010);
        wait_empty();
        chk("pkt_cnt_after_reset", pkt_cnt, 16'd1);
        chk("drop_cnt_after_reset", drop_cnt, 16'd0);

        // Saturation and clear priority
        no_out = 1'b1;
        send_pkt(4'b0000, 1'b0, 1, 1'b0, 4'h0, 1'b0, 4'h0);
        no_out = 1'b0;
        chk("drop_cnt_pre_clr", drop_cnt, 16'd1);
        for (int p = 0; p < 65534; p++) begin
            send_pkt(4'b0001, 1'b0, 1, 1'b1, 4'b0001, 1'b0, 4'b0001);
        end
        chk("pkt_cnt_full", pkt_cnt, 16'hFFFF);
        send_pkt(4'b0001, 1'b0, 1, 1'b1, 4'b0001, 1'b0, 4'b0001);
        chk("pkt_cnt_saturated", pkt_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        send_pkt(4'b0001, 1'b0, 1, 1'b1, 4'b0001, 1'b0, 4'b0001);
        cnt_clr = 1'b0;
        chk("pkt_cnt_clr_priority", pkt_cnt, 16'd0);
        chk("drop_cnt_clr", drop_cnt, 16'd0);
        send_pkt(4'b0001, 1'b0, 1, 1'b1, 4'b0001, 1'b0, 4'b0001);
        wait_empty();
        chk("pkt_cnt_after_clr", pkt_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_route_decode.md
AXIS_ROUTE_DECODE -- requirements
Module: axis_route_decode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream data width in bits.
REQ-002 SHALL have parameter M_COUNT, default 4, number of downstream fork ports.
REQ-003 SHALL have parameter ROUTE_LSB, default 56, LSB of the M_COUNT-bit destination mask in the header beat.
REQ-004 SHALL have parameter FORK_BIT, default 60+M_COUNT-4, header bit requesting multicast (must not overlap the route field).
REQ-005 SHALL have ports, in order:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- port_en  in  M_COUNT  static per-port enable mask, ANDed with the header route
- cnt_clr  in  1  synchronous clear of both counters
- s_axis_tdata / tlast / tvalid  in  DATA_WIDTH / 1 / 1  input frame stream
- s_axis_tready  out  1  input ready
- m_axis_tdata / tlast / tvalid  out  DATA_WIDTH / 1 / 1  output stream toward the fork arbiter
- m_axis_tready  in  1  output ready
- m_oen  out  M_COUNT  per-port output enable, valid with m_axis_tvalid
- m_fork_enable  out  1  multicast flag, valid with m_axis_tvalid
- m_single_mask  out  M_COUNT  one-hot unicast port, valid with m_axis_tvalid
- pkt_cnt  out  16  packets forwarded, saturating
- drop_cnt  out  16  packets dropped, saturating

Function
REQ-006 SHALL treat the first accepted beat after reset, or after a tlast beat, as the header beat.
REQ-007 SHALL compute route = s_axis_tdata[ROUTE_LSB +: M_COUNT] & port_en on the header beat.
REQ-008 SHALL latch route, fork and single values on the header beat and hold them unchanged on every beat of that packet, header included.
REQ-009 SHALL set m_oen = route.
REQ-010 SHALL set m_fork_enable = 1 only when header FORK_BIT = 1 and popcount(route) >= 2.
REQ-011 SHALL set m_single_mask to the lowest set bit of route, or all zero if route = 0.
REQ-012 SHALL use FSM states HEAD, PASS and DROP.
- HEAD: header with route != 0 and tlast = 0 -> PASS; route = 0 and tlast = 0 -> DROP; single-beat packet (tlast = 1) stays in HEAD.
- PASS/DROP: return to HEAD on the accepted tlast beat.
REQ-013 SHALL, in DROP and for a route = 0 header, accept beats (s_axis_tready = 1) and never present them on m_axis.
REQ-014 SHALL forward data through a 2-entry skid register slice: one-cycle latency, full throughput, s_axis_tready registered (no combinational tready path).
REQ-015 SHALL hold m_axis_tvalid, data and sideband stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-016 SHALL increment pkt_cnt on acceptance of a forwarded tlast beat and drop_cnt on acceptance of a dropped tlast beat, each saturating at 0xFFFF.
REQ-017 SHALL give cnt_clr priority over a simultaneous increment: the counter reads 0 next cycle.
REQ-018 SHALL apply a port_en change only at the next header beat, never mid-packet.

Reset
REQ-019 SHALL, while rst_n = 0, hold m_axis_tvalid = 0, s_axis_tready = 0, FSM = HEAD, skid buffer empty, all sideband outputs = 0, pkt_cnt = drop_cnt = 0.
REQ-020 SHALL drive s_axis_tready = 1 on the first clock edge after rst_n deasserts.
REQ-021 SHALL discard a packet interrupted by reset, and SHALL treat the next accepted beat after reset as a header.

Structure
REQ-022 SHALL take the FSM state encoding and the popcount/lowest-set-bit functions from the shared package axis_pkg.
REQ-023 SHALL implement the skid slice as sub-module axis_skid_slice, carrying {tdata, tlast, oen, fork_enable, single_mask} as a single payload.

Verification
REQ-024 Unicast: header route=4'b0100, FORK=0, 3 beats, port_en=4'hF -> m_oen=4'b0100, m_fork_enable=0, m_single_mask=4'b0100 on all 3 beats; pkt_cnt=1.
REQ-025 Multicast: route=4'b1011, FORK=1, port_en=4'b0111 -> m_oen=4'b0011, m_fork_enable=1, m_single_mask=4'b0001.
REQ-026 Drop: route=4'b1000, port_en=4'b0111, 5-beat packet -> no m_axis_tvalid, s_axis_tready stays 1, drop_cnt=1, next packet forwarded.
REQ-027 Backpressure: random m_axis_tready at 50%, 1000 beats -> beat order and data identical, sideband stable while stalled, 100% throughput when m_axis_tready=1.
REQ-028 Reset mid-packet: rst_n low during beat 2 of 4 -> outputs at reset values; first beat after release decoded as a header.
REQ-029 Saturation: preload 0xFFFF forwarded packets, then one more -> pkt_cnt stays 0xFFFF; cnt_clr together with a tlast beat -> pkt_cnt=0.
